systolic_feed_skewer: RTL
=========================

# systolic_feed_skewer

Upstream feeder for the systolic-array-with-buffer stage. It accepts one K-slice per beat: an A column of ARR_HEIGHT elements and a B row of ARR_WIDTH elements. It applies the diagonal skew the array needs (lane i delayed i cycles) and drives the array's west/north inputs. It also generates the single-cycle done flag that the downstream stage's done delay chain expects after the final slice.

## Interface
- WIDTH, 16, element width in bits (opaque; int or float bit pattern).
- ARR_HEIGHT, 4, number of A lanes (array rows).
- ARR_WIDTH, 4, number of B lanes (array columns).
- K_BITS, 8, width of the slice-count field.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  pulse; begins a tile when IDLE.
- k_len  in  K_BITS  number of slices in the tile; sampled with start.
- in_valid  in  1  a_vec/b_vec carry a slice.
- in_ready  out  1  block accepts a slice this cycle.
- a_vec  in  ARR_HEIGHT*WIDTH  A column; lane i = bits [i*WIDTH +: WIDTH].
- b_vec  in  ARR_WIDTH*WIDTH  B row; same lane packing.
- out_a  out  ARR_HEIGHT*WIDTH  skewed A, to the array's in_a.
- out_b  out  ARR_WIDTH*WIDTH  skewed B, to the array's in_b.
- done_flag  out  1  one-cycle pulse, to the array's in_done_flag.
- busy  out  1  high in LOAD and DRAIN.

## Operation
- FSM states: IDLE, LOAD, DRAIN.
- IDLE to LOAD: when start=1 and k_len≠0. Load the beat counter with k_len.
  - start with k_len=0 is ignored.
  - start in LOAD or DRAIN is ignored.
- LOAD:
  - in_ready=1; it depends on state only, never on in_valid.
  - Accept when in_valid && in_ready, then decrement the counter.
  - On the accept that brings the counter to 0, go to DRAIN.
- DRAIN:
  - in_ready=0.
  - Lasts exactly max(ARR_HEIGHT,ARR_WIDTH)-1 cycles, then IDLE.
  - If that value is 0, go straight to IDLE.
- Lane injection:
  - An accepted slice is injected into lane 0 of every delay line.
  - In any cycle with no accept, all-zero elements are injected (a bubble).
  - A bubble forms a full zero anti-diagonal, which contributes nothing to any PE sum.
- Skew:
  - A lane i output = A element i delayed i+1 register stages from the accept edge.
  - B lane j is handled the same way, with j+1 stages.
- done_flag: asserted in the cycle in which the last slice's lane-0 elements are on out_a/out_b.
- Elements pass through unmodified: no arithmetic, no width change.

## Timing
- Reset (reset=0), asynchronous:
  - state=IDLE.
  - All delay registers, out_a and out_b are 0.
  - done_flag=0, busy=0, in_ready=0.
- Reset mid-tile: the tile is dropped entirely and no done_flag is issued. After release, the block waits for a new start.
- Latency, slice accepted at edge t:
  - A/B lane 0 is valid in cycle t+1.
  - Lane i is valid in cycle t+1+i.
- A start sampled at edge s makes in_ready=1 from cycle s+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Simultaneous events:
  - Last accept and a start in the same cycle: start is ignored.
  - The last DRAIN cycle with start=1: start is ignored. The block must be IDLE when start is sampled.

## Configuration
- SKEW_BUBBLE_COUNT_EN defined:
  - Adds output bubble_cnt [K_BITS-1:0].
  - Counts LOAD cycles with no accept and saturates at all-ones.
  - Cleared to 0 by reset and by an accepted start.
- SKEW_BUBBLE_COUNT_EN undefined: the port and the counter are absent. Other behaviour is identical.

## Structure
- Shared package systolic_pkg holds:
  - FSM state enum feed_state_t (IDLE, LOAD, DRAIN).
  - Localparam helper for max(ARR_HEIGHT,ARR_WIDTH).
- One sub-module, skew_lane_delay:
  - Parameters DEPTH, WIDTH.
  - A chain of async-active-low-reset registers.
  - Instantiated once per lane with DEPTH=i+1.

## Test plan
- Reset: hold reset=0 with random inputs. Then out_a=0, out_b=0, done_flag=0, busy=0 and in_ready=0 throughout.
- Back-to-back tile, 4x4, k_len=3:
  - Stimulus: a_vec slices {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, accepted at edges t..t+2.
  - A lane 0 shows 1,5,9 in cycles t+1..t+3.
  - A lane 3 shows 4,8,12 in cycles t+4..t+6.
  - done_flag is high only in t+3.
  - busy falls after 3 DRAIN cycles.
- Stall: k_len=2, slices {1,…} then {5,…}, in_valid=0 for one cycle between them. Lane 0 shows 1,0,5, and every lane shows its 0 one cycle after lane i-1.
- Ignored starts:
  - start with k_len=0 leaves busy=0.
  - start during LOAD with k_len=2 does not change the remaining count. The tile ends after the original k_len.
- Reset mid-LOAD after 1 of 3 slices: outputs are 0 immediately and no done_flag appears. A new start with k_len=1 then completes normally.
- With SKEW_BUBBLE_COUNT_EN, the stall scenario gives bubble_cnt=1 at tile end. It returns to 0 on the next accepted start.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feed path.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } feed_state_t;

  // Larger of the two array dimensions; sets the skew depth and drain length.
  function automatic int unsigned max_dim(input int unsigned h, input int unsigned w);
    return (h > w) ? h : w;
  endfunction

endpackage

// File: rtl/skew_lane_delay.sv
// Fixed-depth register chain for one skewed lane; output is the last stage.
module skew_lane_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feed_skewer.sv
// Skews A/B slices diagonally into the systolic array and flags the final slice.
// Optional SKEW_BUBBLE_COUNT_EN adds bubble_cnt (LOAD cycles without an accept).
module systolic_feed_skewer
  import systolic_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ARR_HEIGHT = 4,
  parameter int unsigned ARR_WIDTH  = 4,
  parameter int unsigned K_BITS     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [K_BITS-1:0]           k_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ARR_HEIGHT*WIDTH-1:0] a_vec,
  input  logic [ARR_WIDTH*WIDTH-1:0]  b_vec,
  output logic [ARR_HEIGHT*WIDTH-1:0] out_a,
  output logic [ARR_WIDTH*WIDTH-1:0]  out_b,
  output logic                        done_flag,
`ifdef SKEW_BUBBLE_COUNT_EN
  output logic [K_BITS-1:0]           bubble_cnt,
`endif
  output logic                        busy
);

  localparam int unsigned MAX_DIM   = max_dim(ARR_HEIGHT, ARR_WIDTH);
  localparam int unsigned DRAIN_LEN = MAX_DIM - 1;
  localparam int unsigned DW        = $clog2(MAX_DIM + 1);

  feed_state_t       state;
  logic [K_BITS-1:0] cnt;
  logic [DW-1:0]     dcnt;
  logic              accept;

  // in_ready is high exactly while in LOAD, so this is the handshake.
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      done_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (k_len != '0)) begin
            state    <= LOAD;
            cnt      <= k_len;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            cnt <= cnt - K_BITS'(1);
            if (cnt == K_BITS'(1)) begin
              done_flag <= 1'b1;
              in_ready  <= 1'b0;
              if (DRAIN_LEN == 0) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DRAIN;
                dcnt  <= DW'(DRAIN_LEN);
              end
            end
          end
        end
        DRAIN: begin
          if (dcnt == DW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            dcnt <= dcnt - DW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef SKEW_BUBBLE_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if ((state == IDLE) && start && (k_len != '0)) begin
      bubble_cnt <= '0;
    end else if ((state == LOAD) && !accept && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + K_BITS'(1);
    end
  end
`endif

  // Non-accept cycles inject zeros so every bubble is a clean zero anti-diagonal.
  for (genvar i = 0; i < int'(ARR_HEIGHT); i++) begin : g_a_lane
    logic [WIDTH-1:0] a_in;
    assign a_in = accept ? a_vec[i*WIDTH +: WIDTH] : '0;
    skew_lane_delay #(.DEPTH(i + 1), .WIDTH(WIDTH)) u_dly (
      .clk   (clk),
      .reset (reset),
      .din   (a_in),
      .dout  (out_a[i*WIDTH +: WIDTH])
    );
  end

  for (genvar j = 0; j < int'(ARR_WIDTH); j++) begin : g_b_lane
    logic [WIDTH-1:0] b_in;
    assign b_in = accept ? b_vec[j*WIDTH +: WIDTH] : '0;
    skew_lane_delay #(.DEPTH(j + 1), .WIDTH(WIDTH)) u_dly (
      .clk   (clk),
      .reset (reset),
      .din   (b_in),
      .dout  (out_b[j*WIDTH +: WIDTH])
    );
  end

endmodule
